// File: rtl/mem_stage.sv
//==============================================================================
// Module      : mem_stage
// Description : Memory stage of a five-stage MIPS pipeline. Performs a
//               word-wide data-memory access addressed by the EXE-stage ALU
//               result and registers the results into the MEM/WB pipeline
//               register. Stores are synchronous. Loads read the memory
//               combinationally and are captured at the clock edge, which
//               gives one cycle of latency.
// Revision    : 1.0 - initial release
//
// Optional feature macro: MEM_BOUNDS_CHECK_EN
//   Defined   : accesses outside [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS) or not
//               word aligned are blocked. Such a store is suppressed, such a
//               load returns 0, and mem_fault is set for that instruction.
//   Undefined : the word index wraps modulo MEM_WORDS, address bits [1:0]
//               are ignored, and mem_fault is always 0.
//
// Parameters:
//   WORD_SIZE      datapath width in bits
//   MEM_WORDS      data-memory depth in words (power of two, at least 2)
//   BASE_ADDR      byte address that maps to word 0
//
// Ports:
//   clk            pipeline clock, rising edge
//   rst            asynchronous active-high reset (outputs and memory to 0)
//   freeze         holds MEM/WB and suppresses memory writes
//   MEM_R_EN       load in MEM
//   MEM_W_EN       store in MEM
//   WB_EN_in       instruction writes the register file
//   destIn         destination register number
//   ALU_result     ALU output (byte address for loads and stores)
//   ST_value       store data
//   WB_EN          registered WB_EN_in
//   MEM_R_EN_out   registered MEM_R_EN (selects the write-back mux)
//   destOut        registered destIn
//   ALU_result_out registered ALU_result
//   dataMem_out    registered load data (0 when not a load)
//   mem_fault      registered access fault
//==============================================================================
`default_nettype none

module mem_stage #(
  parameter int WORD_SIZE = 32,
  parameter int MEM_WORDS = 256,
  parameter int BASE_ADDR = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 MEM_R_EN,
  input  logic                 MEM_W_EN,
  input  logic                 WB_EN_in,
  input  logic [4:0]           destIn,
  input  logic [WORD_SIZE-1:0] ALU_result,
  input  logic [WORD_SIZE-1:0] ST_value,
  output logic                 WB_EN,
  output logic                 MEM_R_EN_out,
  output logic [4:0]           destOut,
  output logic [WORD_SIZE-1:0] ALU_result_out,
  output logic [WORD_SIZE-1:0] dataMem_out,
  output logic                 mem_fault
);

  localparam int c_IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [WORD_SIZE-1:0] c_BASE     = WORD_SIZE'(BASE_ADDR);
  localparam logic [1:0]           c_BASE_LO  = c_BASE[1:0];
  localparam logic [c_IDX_W-1:0]   c_BASE_IDX = c_BASE[c_IDX_W+1:2];

  //--------------------------------------------------------------------------
  // Storage and pipeline registers
  //--------------------------------------------------------------------------
  logic [WORD_SIZE-1:0] r_mem [MEM_WORDS];

  logic                 r_wb_en;
  logic                 r_mem_r_en;
  logic [4:0]           r_dest;
  logic [WORD_SIZE-1:0] r_alu_result;
  logic [WORD_SIZE-1:0] r_data;
  logic                 r_fault;

  //--------------------------------------------------------------------------
  // Word index: ((ALU_result - BASE_ADDR) >> 2) mod MEM_WORDS.
  // Only the index-sized slice of the difference is needed. It equals the
  // difference of the [c_IDX_W+1:2] slices minus the borrow out of the two
  // low address bits, so the full-width subtraction is never built here.
  //--------------------------------------------------------------------------
  logic               w_borrow;
  logic [c_IDX_W-1:0] w_idx;

  assign w_borrow = (ALU_result[1:0] < c_BASE_LO);
  assign w_idx    = ALU_result[c_IDX_W+1:2] - c_BASE_IDX - c_IDX_W'(w_borrow);

  //--------------------------------------------------------------------------
  // Access qualification
  //--------------------------------------------------------------------------
  logic w_access_ok;
  logic w_fault;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [WORD_SIZE-1:0] c_SPAN = WORD_SIZE'(4 * MEM_WORDS);

  logic [WORD_SIZE-1:0] w_offset;
  logic                 w_in_range;

  // An address below BASE_ADDR wraps to a huge unsigned offset, so the single
  // compare covers both the lower and the upper bound.
  assign w_offset    = ALU_result - c_BASE;
  assign w_in_range  = (w_offset < c_SPAN) && (ALU_result[1:0] == 2'b00);
  assign w_access_ok = w_in_range;
  assign w_fault     = (MEM_R_EN | MEM_W_EN) & ~w_in_range;
`else
  assign w_access_ok = 1'b1;
  assign w_fault     = 1'b0;
`endif

  logic                 w_we;
  logic [WORD_SIZE-1:0] w_rdata;

  assign w_we    = MEM_W_EN & ~freeze & w_access_ok;
  // The read uses the pre-edge memory contents, so a simultaneous read and
  // write of the same word returns the old data.
  assign w_rdata = (MEM_R_EN & w_access_ok) ? r_mem[w_idx] : '0;

  //--------------------------------------------------------------------------
  // Data memory: synchronous write, asynchronous clear of every word
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_we) begin
      r_mem[w_idx] <= ST_value;
    end
  end

  //--------------------------------------------------------------------------
  // MEM/WB pipeline register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_en      <= 1'b0;
      r_mem_r_en   <= 1'b0;
      r_dest       <= '0;
      r_alu_result <= '0;
      r_data       <= '0;
      r_fault      <= 1'b0;
    end else if (!freeze) begin
      r_wb_en      <= WB_EN_in;
      r_mem_r_en   <= MEM_R_EN;
      r_dest       <= destIn;
      r_alu_result <= ALU_result;
      r_data       <= w_rdata;
      r_fault      <= w_fault;
    end
  end

  assign WB_EN          = r_wb_en;
  assign MEM_R_EN_out   = r_mem_r_en;
  assign destOut        = r_dest;
  assign ALU_result_out = r_alu_result;
  assign dataMem_out    = r_data;
  assign mem_fault      = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//==============================================================================
// Module      : tb_mem_stage
// Description : Self-checking directed testbench for mem_stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic        WB_EN_in;
  logic [4:0]  destIn;
  logic [31:0] ALU_result;
  logic [31:0] ST_value;
  logic        WB_EN;
  logic        MEM_R_EN_out;
  logic [4:0]  destOut;
  logic [31:0] ALU_result_out;
  logic [31:0] dataMem_out;
  logic        mem_fault;

  int errors = 0;
  int checks = 0;

  mem_stage #(
    .WORD_SIZE (32),
    .MEM_WORDS (256),
    .BASE_ADDR (1024)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .MEM_R_EN       (MEM_R_EN),
    .MEM_W_EN       (MEM_W_EN),
    .WB_EN_in       (WB_EN_in),
    .destIn         (destIn),
    .ALU_result     (ALU_result),
    .ST_value       (ST_value),
    .WB_EN          (WB_EN),
    .MEM_R_EN_out   (MEM_R_EN_out),
    .destOut        (destOut),
    .ALU_result_out (ALU_result_out),
    .dataMem_out    (dataMem_out),
    .mem_fault      (mem_fault)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic w, input logic wb,
                       input logic [4:0] d, input logic [31:0] a,
                       input logic [31:0] v);
    MEM_R_EN   = r;
    MEM_W_EN   = w;
    WB_EN_in   = wb;
    destIn     = d;
    ALU_result = a;
    ST_value   = v;
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    freeze = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #1;
    checks++; if (WB_EN !== 1'b0) begin errors++; $display("FAIL reset_wb_en: got %0b want 0", WB_EN); end
    checks++; if (MEM_R_EN_out !== 1'b0) begin errors++; $display("FAIL reset_mem_r_en: got %0b want 0", MEM_R_EN_out); end
    checks++; if (destOut !== 5'd0) begin errors++; $display("FAIL reset_dest: got %0d want 0", destOut); end
    checks++; if (ALU_result_out !== 32'h0) begin errors++; $display("FAIL reset_alu: got %h want 0", ALU_result_out); end
    checks++; if (dataMem_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", dataMem_out); end
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0b want 0", mem_fault); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_pass_through();
    drive(1'b0, 1'b0, 1'b1, 5'd7, 32'h55, 32'h0);
    step();
    checks++; if (WB_EN !== 1'b1) begin errors++; $display("FAIL pt_wb_en: got %0b want 1", WB_EN); end
    checks++; if (destOut !== 5'd7) begin errors++; $display("FAIL pt_dest: got %0d want 7", destOut); end
    checks++; if (ALU_result_out !== 32'h55) begin errors++; $display("FAIL pt_alu: got %h want 00000055", ALU_result_out); end
    checks++; if (dataMem_out !== 32'h0) begin errors++; $display("FAIL pt_data: got %h want 0", dataMem_out); end
    checks++; if (MEM_R_EN_out !== 1'b0) begin errors++; $display("FAIL pt_mem_r_en: got %0b want 0", MEM_R_EN_out); end
  endtask

  task automatic test_store_load();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd1024, 32'hDEAD_BEEF);
    step();
    checks++; if (dataMem_out !== 32'h0) begin errors++; $display("FAIL st_data_zero: got %h want 0", dataMem_out); end
    drive(1'b1, 1'b0, 1'b1, 5'd3, 32'd1024, 32'h0);
    step();
    checks++; if (dataMem_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_data: got %h want deadbeef", dataMem_out); end
    checks++; if (MEM_R_EN_out !== 1'b1) begin errors++; $display("FAIL ld_mem_r_en: got %0b want 1", MEM_R_EN_out); end
    checks++; if (destOut !== 5'd3) begin errors++; $display("FAIL ld_dest: got %0d want 3", destOut); end
    checks++; if (ALU_result_out !== 32'd1024) begin errors++; $display("FAIL ld_alu: got %0d want 1024", ALU_result_out); end
  endtask

  task automatic test_freeze();
    // Word 1 gets a known value, then a load of word 0 sets known outputs.
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd1028, 32'hAAAA_5555);
    step();
    drive(1'b1, 1'b0, 1'b1, 5'd9, 32'd1024, 32'h0);
    step();
    // Pending store frozen for three cycles: outputs hold.
    drive(1'b0, 1'b1, 1'b0, 5'd12, 32'd1028, 32'h1234_5678);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (dataMem_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL frz_data[%0d]: got %h want deadbeef", i, dataMem_out); end
      checks++; if (destOut !== 5'd9) begin errors++; $display("FAIL frz_dest[%0d]: got %0d want 9", i, destOut); end
      checks++; if (MEM_R_EN_out !== 1'b1 || WB_EN !== 1'b1) begin errors++; $display("FAIL frz_ctrl[%0d]: got r=%0b wb=%0b want r=1 wb=1", i, MEM_R_EN_out, WB_EN); end
      checks++; if (ALU_result_out !== 32'd1024) begin errors++; $display("FAIL frz_alu[%0d]: got %0d want 1024", i, ALU_result_out); end
    end
    // Replace the frozen store by a load: word 1 must still hold its old value.
    freeze = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 5'd10, 32'd1028, 32'h0);
    step();
    checks++; if (dataMem_out !== 32'hAAAA_5555) begin errors++; $display("FAIL frz_no_write: got %h want aaaa5555", dataMem_out); end
    // Held store lands in the first unfrozen cycle.
    drive(1'b0, 1'b1, 1'b0, 5'd12, 32'd1028, 32'h1234_5678);
    freeze = 1'b1;
    step();
    step();
    freeze = 1'b0;
    step();
    checks++; if (ALU_result_out !== 32'd1028 || MEM_R_EN_out !== 1'b0) begin errors++; $display("FAIL frz_release: got alu=%0d r=%0b want alu=1028 r=0", ALU_result_out, MEM_R_EN_out); end
    drive(1'b1, 1'b0, 1'b1, 5'd11, 32'd1028, 32'h0);
    step();
    checks++; if (dataMem_out !== 32'h1234_5678) begin errors++; $display("FAIL frz_late_write: got %h want 12345678", dataMem_out); end
  endtask

  task automatic test_read_write_same();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd1032, 32'h1);
    step();
    drive(1'b1, 1'b1, 1'b1, 5'd4, 32'd1032, 32'h2);
    step();
    checks++; if (dataMem_out !== 32'h1) begin errors++; $display("FAIL rw_old: got %h want 00000001", dataMem_out); end
    drive(1'b1, 1'b0, 1'b1, 5'd4, 32'd1032, 32'h0);
    step();
    checks++; if (dataMem_out !== 32'h2) begin errors++; $display("FAIL rw_new: got %h want 00000002", dataMem_out); end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd1036, 32'h0000_0101);
    step();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd1040, 32'h0000_0202);
    step();
    drive(1'b1, 1'b0, 1'b1, 5'd1, 32'd1036, 32'h0);
    step();
    checks++; if (dataMem_out !== 32'h0000_0101) begin errors++; $display("FAIL b2b_ld3: got %h want 00000101", dataMem_out); end
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd1044, 32'h0000_0303);
    step();
    drive(1'b1, 1'b0, 1'b1, 5'd2, 32'd1044, 32'h0);
    step();
    checks++; if (dataMem_out !== 32'h0000_0303) begin errors++; $display("FAIL b2b_raw: got %h want 00000303", dataMem_out); end
    drive(1'b1, 1'b0, 1'b1, 5'd3, 32'd1040, 32'h0);
    step();
    checks++; if (dataMem_out !== 32'h0000_0202) begin errors++; $display("FAIL b2b_ld4: got %h want 00000202", dataMem_out); end
    checks++; if (destOut !== 5'd3) begin errors++; $display("FAIL b2b_dest: got %0d want 3", destOut); end
  endtask

  task automatic test_out_of_range();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd2048, 32'hCAFE_F00D);
    step();
`ifdef MEM_BOUNDS_CHECK_EN
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("FAIL oor_st_fault: got %0b want 1", mem_fault); end
    drive(1'b1, 1'b0, 1'b1, 5'd5, 32'd1024, 32'h0);
    step();
    checks++; if (dataMem_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL oor_word0: got %h want deadbeef", dataMem_out); end
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL oor_inrange_fault: got %0b want 0", mem_fault); end
    drive(1'b1, 1'b0, 1'b1, 5'd5, 32'd1025, 32'h0);
    step();
    checks++; if (dataMem_out !== 32'h0 || mem_fault !== 1'b1) begin errors++; $display("FAIL oor_misalign: got data=%h fault=%0b want data=0 fault=1", dataMem_out, mem_fault); end
    drive(1'b1, 1'b0, 1'b1, 5'd5, 32'd1020, 32'h0);
    step();
    checks++; if (dataMem_out !== 32'h0 || mem_fault !== 1'b1) begin errors++; $display("FAIL oor_below: got data=%h fault=%0b want data=0 fault=1", dataMem_out, mem_fault); end
    drive(1'b0, 1'b0, 1'b1, 5'd5, 32'd4000, 32'h0);
    step();
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL oor_nonmem_fault: got %0b want 0", mem_fault); end
`else
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL oor_st_fault: got %0b want 0", mem_fault); end
    drive(1'b1, 1'b0, 1'b1, 5'd5, 32'd1024, 32'h0);
    step();
    checks++; if (dataMem_out !== 32'hCAFE_F00D) begin errors++; $display("FAIL oor_wrap: got %h want cafef00d", dataMem_out); end
    drive(1'b1, 1'b0, 1'b1, 5'd5, 32'd1026, 32'h0);
    step();
    checks++; if (dataMem_out !== 32'hCAFE_F00D) begin errors++; $display("FAIL oor_misalign: got %h want cafef00d", dataMem_out); end
    // 1020 is one word below the base and wraps to word 255; 1023 maps there too.
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd1020, 32'h0BAD_CAFE);
    step();
    drive(1'b1, 1'b0, 1'b1, 5'd5, 32'd1023, 32'h0);
    step();
    checks++; if (dataMem_out !== 32'h0BAD_CAFE) begin errors++; $display("FAIL oor_below_wrap: got %h want 0badcafe", dataMem_out); end
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL oor_fault_const: got %0b want 0", mem_fault); end
`endif
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd1024, 32'h0000_0077);
    step();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd1028, 32'h0000_0088);
    step();
    drive(1'b1, 1'b0, 1'b1, 5'd21, 32'd1028, 32'h0);
    step();
    checks++; if (dataMem_out !== 32'h0000_0088) begin errors++; $display("FAIL ar_pre: got %h want 00000088", dataMem_out); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (WB_EN !== 1'b0 || MEM_R_EN_out !== 1'b0 || destOut !== 5'd0) begin errors++; $display("FAIL ar_ctrl: got wb=%0b r=%0b dest=%0d want 0", WB_EN, MEM_R_EN_out, destOut); end
    checks++; if (ALU_result_out !== 32'h0 || dataMem_out !== 32'h0 || mem_fault !== 1'b0) begin errors++; $display("FAIL ar_data: got alu=%h data=%h fault=%0b want 0", ALU_result_out, dataMem_out, mem_fault); end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 5'd22, 32'd1024, 32'h0);
    step();
    checks++; if (dataMem_out !== 32'h0 || MEM_R_EN_out !== 1'b1) begin errors++; $display("FAIL ar_word0: got data=%h r=%0b want data=0 r=1", dataMem_out, MEM_R_EN_out); end
    drive(1'b1, 1'b0, 1'b1, 5'd23, 32'd1028, 32'h0);
    step();
    checks++; if (dataMem_out !== 32'h0) begin errors++; $display("FAIL ar_word1: got %h want 0", dataMem_out); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_store_load();
    test_freeze();
    test_read_write_same();
    test_back_to_back();
    test_out_of_range();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage MIPS pipeline. It consumes the EXE-stage ALU result (effective address or arithmetic result) together with the store value and control bits, performs a word-wide data-memory access, and registers everything into the MEM/WB pipeline register for the write-back stage. Memory writes are synchronous. Reads are combinational into the MEM/WB register, which gives one cycle of latency.

## Interface
- `WORD_SIZE`, 32: datapath width in bits.
- `MEM_WORDS`, 256: data-memory depth in words; must be a power of two.
- `BASE_ADDR`, 1024: byte address that maps to word 0.

- `clk` input 1: pipeline clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `freeze` input 1: stalls MEM/WB and suppresses memory writes.
- `MEM_R_EN` input 1: load in MEM.
- `MEM_W_EN` input 1: store in MEM.
- `WB_EN_in` input 1: instruction writes the register file.
- `destIn` input 5: destination register number.
- `ALU_result` input WORD_SIZE: ALU output (address for loads and stores).
- `ST_value` input WORD_SIZE: store data.
- `WB_EN` output 1: registered WB_EN_in.
- `MEM_R_EN_out` output 1: registered MEM_R_EN; selects the WB mux.
- `destOut` output 5: registered destIn.
- `ALU_result_out` output WORD_SIZE: registered ALU_result.
- `dataMem_out` output WORD_SIZE: registered load data.
- `mem_fault` output 1: registered access fault; see Configuration.

## Operation
- Word index: `idx = ((ALU_result - BASE_ADDR) >> 2) mod MEM_WORDS`.
  - Subtraction is unsigned WORD_SIZE-bit.
  - Address bits [1:0] are ignored.
- Store:
  - Condition: MEM_W_EN=1 and freeze=0.
  - Action: `mem[idx] <= ST_value` at the rising edge of clk.
  - If freeze=1, the write is dropped. The upstream register holds the instruction, so the write occurs in the first unfrozen cycle.
- Load:
  - `mem[idx]` is read combinationally and captured into dataMem_out at the edge.
  - If MEM_R_EN=0, dataMem_out captures 0.
- MEM_R_EN and MEM_W_EN both 1:
  - The write is performed.
  - dataMem_out captures the pre-write word.
- MEM/WB register:
  - freeze=0: all outputs load their inputs every edge.
  - freeze=1: all outputs hold.
- Reset (rst=1, asynchronous):
  - All outputs clear to 0.
  - All MEM_WORDS memory words clear to 0.
  - Reset wins over freeze and over a write on the same edge.
  - On release, the first rising edge with rst=0 behaves normally.

## Timing
- Latency: inputs at edge N are visible on the outputs after edge N+1.
- Throughput: one access per cycle.
- Read-after-write:
  - A store at edge N is visible to a load presented in the cycle after edge N.
  - That load's data appears on dataMem_out after edge N+1.
- Same-cycle read and write of one word returns the old data.
- Reset asserted mid-stall or mid-access takes effect immediately, with no clock edge needed.
- No combinational path from any input to any output.

## Configuration
- Macro: `MEM_BOUNDS_CHECK_EN`.
- Defined:
  - An access is in range when `BASE_ADDR <= ALU_result < BASE_ADDR + 4*MEM_WORDS` and `ALU_result[1:0] == 0`.
  - For a load or store outside that range:
    - the store is suppressed;
    - the load captures dataMem_out = 0;
    - mem_fault is registered as 1 for that instruction, following the same freeze/reset rules as the other outputs.
  - mem_fault is 0 for in-range accesses and for non-memory instructions.
- Undefined:
  - The index wraps modulo MEM_WORDS.
  - Misalignment is ignored.
  - mem_fault is constant 0; the port is always present.

## Test plan
- **Store then load.** Store 0xDEADBEEF at address 1024, then load from 1024 in the next cycle. Required: dataMem_out = 0xDEADBEEF one edge after the load; MEM_R_EN_out=1.
- **Freeze holds state.** Set freeze=1 for 3 cycles while a store to 1028 with value 0x12345678 is pending. Required:
  - memory at word 1 is unchanged during the freeze;
  - all outputs hold;
  - after freeze drops, the write lands and a subsequent load from 1028 returns 0x12345678.
- **Simultaneous read and write.** Word 2 holds 0x1 (address 1032). Apply MEM_R_EN=MEM_W_EN=1 with ST_value=0x2. Required: dataMem_out=0x1; a later load returns 0x2.
- **Asynchronous reset mid-operation.** After several stores, pulse rst between clock edges. Required: all outputs are 0 immediately; a load from 1024 returns 0.
- **Out-of-range address.** Store to address 1024+4*256=2048.
  - With MEM_BOUNDS_CHECK_EN: mem_fault=1 and word 0 is unchanged.
  - Without it: word 0 is written and mem_fault=0.
- **Pass-through fields.** Non-memory instruction with WB_EN_in=1, destIn=5'd7, ALU_result=0x55. Required: WB_EN=1, destOut=7, ALU_result_out=0x55, dataMem_out=0, all after one edge.
